// File: rtl/victim_write_buffer_pkg.sv
// Shared types for the victim write buffer: entry record, drain FSM states and line-address helper.
// Entry field widths are fixed here; the top-level ADDR_W/LINE_W parameters must agree with them.
package ewb_pkg;

    localparam int EWB_ADDR_W   = 32;
    localparam int EWB_LINE_W   = 256;
    localparam int EWB_OFFSET_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [EWB_ADDR_W-1:0] addr;
        logic [EWB_LINE_W-1:0] data;
    } ewb_entry_t;

    typedef enum logic {
        EWB_IDLE,
        EWB_WRITE
    } ewb_state_e;

    // Clears the byte-offset bits so two addresses in the same line compare equal.
    function automatic logic [EWB_ADDR_W-1:0] ewb_line_addr(
        input logic [EWB_ADDR_W-1:0] addr,
        input int unsigned           offset_w
    );
        logic [EWB_ADDR_W-1:0] mask;
        mask = '1 << offset_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/victim_write_buffer_if.sv
// Bus bundle of the victim write buffer: cache push, lookup and memory drain signals.
// The master modport is the environment (cache and memory); slave is the buffer itself.
interface victim_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              push;
    logic              push_ready;
    logic [ADDR_W-1:0] push_addr;
    logic [LINE_W-1:0] push_data;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic              empty;
    logic              full;

    modport master (
        output push, push_addr, push_data, lookup_addr, mem_resp,
        input  push_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata, empty, full
    );

    modport slave (
        input  push, push_addr, push_data, lookup_addr, mem_resp,
        output push_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata, empty, full
    );
endinterface

// File: rtl/victim_write_buffer_match.sv
// DEPTH-way line-address comparator; scans oldest to youngest so the youngest match wins.
// skip_head excludes the head entry (used by coalescing while the head is being written).
module ewb_match
    import ewb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int OFFSET_W = EWB_OFFSET_W,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  ewb_entry_t             entries [DEPTH],
    input  logic       [PTR_W-1:0] head,
    input  logic                   skip_head,
    input  logic [EWB_ADDR_W-1:0]  addr,
    output logic                   hit,
    output logic       [PTR_W-1:0] idx
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            if (entries[head + PTR_W'(k)].valid &&
                !(skip_head && k == 0) &&
                ewb_line_addr(entries[head + PTR_W'(k)].addr, OFFSET_W) ==
                ewb_line_addr(addr, OFFSET_W)) begin
                hit = 1'b1;
                idx = head + PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/victim_write_buffer.sv
// FIFO eviction write buffer with youngest-wins lookup and a two-state memory drain FSM.
// Optional macro VICTIM_WB_COALESCE_EN merges pushes into an already queued copy of the line.
module victim_write_buffer
    import ewb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = EWB_ADDR_W,
    parameter int LINE_W   = EWB_LINE_W,
    parameter int OFFSET_W = EWB_OFFSET_W
) (
    input logic                 clk,
    input logic                 rst,
    victim_write_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    ewb_entry_t       entries [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    ewb_state_e       state_q, state_d;

    logic              full, empty, push_ready;
    logic              push_acc, alloc, pop;
    logic              lk_hit;
    logic [PTR_W-1:0]  lk_idx;
    logic [ADDR_W-1:0] push_addr;
    logic [LINE_W-1:0] lookup_data;

    assign push_addr = bus.push_addr;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = (state_q == EWB_WRITE) && bus.mem_resp;
    assign push_acc  = bus.push && push_ready;

    ewb_match #(.DEPTH(DEPTH), .OFFSET_W(OFFSET_W)) u_lookup (
        .entries   (entries),
        .head      (head_q),
        .skip_head (1'b0),
        .addr      (bus.lookup_addr),
        .hit       (lk_hit),
        .idx       (lk_idx)
    );

`ifdef VICTIM_WB_COALESCE_EN
    logic             co_hit;
    logic [PTR_W-1:0] co_idx;

    // The head is off-limits while its write is in flight so mem_wdata stays stable.
    ewb_match #(.DEPTH(DEPTH), .OFFSET_W(OFFSET_W)) u_coalesce (
        .entries   (entries),
        .head      (head_q),
        .skip_head (state_q == EWB_WRITE),
        .addr      (push_addr),
        .hit       (co_hit),
        .idx       (co_idx)
    );

    assign push_ready = !full || co_hit;
    assign alloc      = push_acc && !co_hit;
`else
    assign push_ready = !full;
    assign alloc      = push_acc;
`endif

    // NOTE: only the valid bits are reset; line data is qualified by valid and needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (pop) begin
                entries[head_q].valid <= 1'b0;
            end
            if (alloc) begin
                entries[tail_q] <= '{valid: 1'b1, addr: push_addr, data: bus.push_data};
            end
`ifdef VICTIM_WB_COALESCE_EN
            if (push_acc && co_hit) begin
                entries[co_idx].data <= bus.push_data;
            end
`endif
        end
    end

    // full/empty come from count, so head == tail is never ambiguous.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc) tail_q <= tail_q + 1'b1;
            if (pop)   head_q <= head_q + 1'b1;
            case ({alloc, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EWB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EWB_IDLE:  if (!empty)       state_d = EWB_WRITE;
            EWB_WRITE: if (bus.mem_resp) state_d = EWB_IDLE;
            default:                     state_d = EWB_IDLE;
        endcase
    end

    assign lookup_data = lk_hit ? entries[lk_idx].data : '0;

    assign bus.push_ready  = push_ready;
    assign bus.lookup_hit  = lk_hit;
    assign bus.lookup_data = lookup_data;
    assign bus.mem_write   = (state_q == EWB_WRITE);
    assign bus.mem_address = ewb_line_addr(entries[head_q].addr, OFFSET_W);
    assign bus.mem_wdata   = entries[head_q].data;
    assign bus.empty       = empty;
    assign bus.full        = full;

endmodule
